// File: rtl/window_pkg.sv
// Shared definitions for the K x K sliding-window generator:
// FSM state encoding and the flat window-bus element offset.
package window_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] PROCESS = 2'd2;

  // LSB of element (r,c) on the row-major, MSB-first window bus
  function automatic int win_lsb(
    input int r,
    input int c,
    input int k,
    input int dw
  );
    return (k * k - 1 - (r * k + c)) * dw;
  endfunction

endpackage

// File: rtl/window_line_buffer.sv
// One image row of pixels: single write port, K combinational
// read ports (one per window column).
module window_line_buffer #(
  parameter int DW = 8,
  parameter int W  = 32,
  parameter int K  = 3,
  parameter int XW = $clog2(W)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [XW-1:0]   waddr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [K*XW-1:0] raddr_i,
  output logic [K*DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    rdata_o = '0;
    for (int c = 0; c < K; c++) begin
      rdata_o[c*DW +: DW] = mem_q[raddr_i[c*XW +: XW]];
    end
  end

endmodule

// File: rtl/window.sv
// Streaming K x K zero-padded window generator over K+1 circular
// line buffers; one window per cycle in raster order.
module window
  import window_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PADDING     = (KERNEL_SIZE - 1) / 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [DATA_WIDTH-1:0]                   pixel_in,
  input  logic                                    pixel_valid,
  input  logic                                    frame_start,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                    window_valid
);

  localparam int DW   = DATA_WIDTH;
  localparam int W    = IMG_WIDTH;
  localparam int H    = IMG_HEIGHT;
  localparam int K    = KERNEL_SIZE;
  localparam int S    = STRIDE;
  localparam int P    = PADDING;
  localparam int NB   = K + 1;
  localparam int BW   = $clog2(NB);
  localparam int NPIX = W * H;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H + S + 1);
  localparam int CW   = $clog2(NPIX + 1);
  localparam int WB   = K * K * DW;
  localparam int R0   = ((P < H - 1) ? P : H - 1) * W
                      + ((P < W - 1) ? P : W - 1);

  logic [1:0]    current_state;
  logic [1:0]    state_d;
  logic [XW-1:0] in_x_q;
  logic [YW-1:0] in_y_q;
  logic [CW-1:0] in_cnt_q;
  logic [XW-1:0] wx_q;
  logic [YW-1:0] wy_q;
  logic [XW-1:0] x_window;
  logic [YW-1:0] y_window;
  logic          last_q;
  logic [WB-1:0] win_q;
  logic          vld_q;

  logic          acc;
  logic          ready;
  logic          emit;
  logic [BW-1:0] wsel;
  logic [K*XW-1:0] raddr;
  logic [WB-1:0] win_d;
  logic [K*DW-1:0] rd [NB];
  logic [K*DW-1:0] rowdat;
  int            ry;
  int            rx;
  int            row;
  int            col;

  assign acc = pixel_valid && (current_state != IDLE)
            && (in_cnt_q < CW'(NPIX)) && !frame_start;
  assign wsel = BW'(int'(in_y_q) % NB);

  // A window is ready once its bottom-right in-image pixel is in
  always_comb begin
    ry = int'(wy_q) + P;
    rx = int'(wx_q) + P;
    if (ry > H - 1) ry = H - 1;
    if (rx > W - 1) rx = W - 1;
    ready = int'(in_cnt_q) > ry * W + rx;
    emit  = (current_state != IDLE) && !last_q
         && ready && !frame_start;
  end

  always_comb begin
    state_d = current_state;
    unique case (current_state)
      IDLE:    state_d = IDLE;
      LOAD:    if (acc && int'(in_cnt_q) == R0) state_d = PROCESS;
      PROCESS: if (last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar b = 0; b < NB; b++) begin : g_lb
    window_line_buffer #(
      .DW(DW),
      .W (W),
      .K (K),
      .XW(XW)
    ) u_lb (
      .clk    (clk),
      .we_i   (acc && (wsel == BW'(b))),
      .waddr_i(in_x_q),
      .wdata_i(pixel_in),
      .raddr_i(raddr),
      .rdata_o(rd[b])
    );
  end

  // Rows/columns outside the image read as zero padding
  always_comb begin
    raddr  = '0;
    win_d  = '0;
    rowdat = '0;
    row    = 0;
    col    = 0;
    for (int c = 0; c < K; c++) begin
      col = int'(wx_q) - P + c;
      if (col >= 0 && col < W) raddr[c*XW +: XW] = XW'(col);
    end
    for (int r = 0; r < K; r++) begin
      row = int'(wy_q) - P + r;
      if (row >= 0 && row < H) begin
        rowdat = rd[BW'(row % NB)];
        for (int c = 0; c < K; c++) begin
          col = int'(wx_q) - P + c;
          if (col >= 0 && col < W)
            win_d[win_lsb(r, c, K, DW) +: DW] = rowdat[c*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      current_state <= IDLE;
      in_x_q        <= '0;
      in_y_q        <= '0;
      in_cnt_q      <= '0;
      wx_q          <= '0;
      wy_q          <= '0;
      x_window      <= '0;
      y_window      <= '0;
      last_q        <= 1'b0;
      win_q         <= '0;
      vld_q         <= 1'b0;
    end else if (frame_start) begin
      current_state <= LOAD;
      in_x_q        <= '0;
      in_y_q        <= '0;
      in_cnt_q      <= '0;
      wx_q          <= '0;
      wy_q          <= '0;
      last_q        <= 1'b0;
      vld_q         <= 1'b0;
    end else begin
      current_state <= state_d;
      vld_q         <= emit;
      if (acc) begin
        in_cnt_q <= in_cnt_q + 1'b1;
        if (in_x_q == XW'(W - 1)) begin
          in_x_q <= '0;
          in_y_q <= in_y_q + 1'b1;
        end else begin
          in_x_q <= in_x_q + 1'b1;
        end
      end
      if (emit) begin
        win_q    <= win_d;
        x_window <= wx_q;
        y_window <= wy_q;
        if (int'(wx_q) + S >= W) begin
          wx_q   <= '0;
          wy_q   <= wy_q + YW'(S);
          last_q <= (int'(wy_q) + S >= H);
        end else begin
          wx_q <= wx_q + XW'(S);
        end
      end
    end
  end

  assign window_out   = win_q;
  assign window_valid = vld_q;

endmodule

// File: tb/tb_window.sv
// Self-checking bench for window: three configurations share the
// input stimulus, a per-frame queue model predicts every window.
module tb_window;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixel_valid;
  logic        frame_start;
  logic [7:0]  pixel_in;
  int          sel;

  always #5 clk = ~clk;

  logic        fs_a, fs_b, fs_c;
  logic [71:0] wo_a, wo_b, wo_c;
  logic        wv_a, wv_b, wv_c;

  assign fs_a = frame_start && (sel == 0);
  assign fs_b = frame_start && (sel == 1);
  assign fs_c = frame_start && (sel == 2);

  window #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) dA (
    .clk(clk), .rst(rst), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .frame_start(fs_a),
    .window_out(wo_a), .window_valid(wv_a)
  );

  window dB (
    .clk(clk), .rst(rst), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .frame_start(fs_b),
    .window_out(wo_b), .window_valid(wv_b)
  );

  window #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(2)) dC (
    .clk(clk), .rst(rst), .pixel_in(pixel_in),
    .pixel_valid(pixel_valid), .frame_start(fs_c),
    .window_out(wo_c), .window_valid(wv_c)
  );

  logic [71:0] wo;
  logic        wv;
  logic [1:0]  st;
  int          wx;
  int          wy;

  assign wo = (sel == 0) ? wo_a : (sel == 1) ? wo_b : wo_c;
  assign wv = (sel == 0) ? wv_a : (sel == 1) ? wv_b : wv_c;
  assign st = (sel == 0) ? dA.current_state
            : (sel == 1) ? dB.current_state : dC.current_state;
  assign wx = (sel == 0) ? int'(dA.x_window)
            : (sel == 1) ? int'(dB.x_window) : int'(dC.x_window);
  assign wy = (sel == 0) ? int'(dA.y_window)
            : (sel == 1) ? int'(dB.y_window) : int'(dC.y_window);

  typedef struct {
    int          y;
    int          x;
    logic [71:0] win;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        me;
  int          img [32][32];
  int          pix_cyc [1024];
  int          checks = 0;
  int          failures = 0;
  int          got = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          mon_en = 1'b0;
  logic [71:0] cap00, cap22, cap44, cap_last;

  task automatic check(string tag, logic [71:0] obs, logic [71:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // Reference: every centre on the stride grid, padded with zeros
  function automatic void build(int w, int h, int s);
    exp_t e;
    int iy, ix;
    exp_q.delete();
    for (int y = 0; y < h; y += s) begin
      for (int x = 0; x < w; x += s) begin
        e.y = y;
        e.x = x;
        e.win = '0;
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 3; c++) begin
            iy = y - 1 + r;
            ix = x - 1 + c;
            if (iy >= 0 && iy < h && ix >= 0 && ix < w)
              e.win[(8 - (r * 3 + c)) * 8 +: 8] = 8'(img[iy][ix]);
          end
        end
        exp_q.push_back(e);
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && wv) begin
      if (got == 0) begin
        first_cyc = cyc;
        check("st_process", 72'(st), 72'(2));
      end
      last_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("extra_win", 72'(1), 72'(0));
      end else begin
        me = exp_q.pop_front();
        check("win", wo, me.win);
        check("ctr_y", 72'(wy), 72'(me.y));
        check("ctr_x", 72'(wx), 72'(me.x));
        if (me.y == 0 && me.x == 0) cap00 = wo;
        if (me.y == 2 && me.x == 2) cap22 = wo;
        if (me.y == 4 && me.x == 4) cap44 = wo;
        if (me.y == 31 && me.x == 31) cap_last = wo;
      end
      got++;
    end
  end

  task automatic send_frame(int w, int h, int s, int mode, int n);
    @(posedge clk); #1;
    frame_start = 1'b1;
    pixel_valid = 1'b0;
    @(posedge clk); #1;
    frame_start = 1'b0;
    check("st_load", 72'(st), 72'(1));
    build(w, h, s);
    got = 0;
    mon_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        pixel_valid = 1'b0;
        @(posedge clk); #1;
      end
      pixel_valid = 1'b1;
      pixel_in = 8'(img[i / w][i % w]);
      @(posedge clk); #1;
      pix_cyc[i] = cyc;
    end
    pixel_valid = 1'b0;
  endtask

  task automatic wait_done(int n, int budget);
    for (int i = 0; i < budget && got < n; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("win_count", 72'(got), 72'(n));
    check("queue_left", 72'(exp_q.size()), 72'(0));
    check("st_idle", 72'(st), 72'(0));
  endtask

  task automatic fill_seq(int w, int h);
    for (int i = 0; i < h; i++)
      for (int j = 0; j < w; j++)
        img[i][j] = i * w + j + 1;
  endtask

  task automatic fill_rand(int w, int h);
    for (int i = 0; i < h; i++)
      for (int j = 0; j < w; j++)
        img[i][j] = int'($urandom_range(0, 255));
  endtask

  initial begin
    rst = 1'b1;
    sel = 0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    pixel_in = '0;
    cap00 = '0;
    cap22 = '0;
    cap44 = '0;
    cap_last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 72'(wv), 72'(0));
    check("rst_out", wo, 72'(0));
    check("rst_state", 72'(st), 72'(0));
    check("rst_xwin", 72'(wx), 72'(0));
    check("rst_ywin", 72'(wy), 72'(0));
    rst = 1'b0;

    // Sequential 5x5 frame, continuous input
    fill_seq(5, 5);
    send_frame(5, 5, 1, 0, 25);
    wait_done(25, 200);
    check("first_lat", 72'(first_cyc), 72'(pix_cyc[6] + 1));
    check("win00", cap00, 72'h000000000102000607);
    check("win22", cap22, 72'h0708090C0D0E111213);
    check("win44", cap44, 72'h131400181900000000);

    // Same frame, pixel_valid toggling every cycle
    cap00 = '0;
    cap22 = '0;
    cap44 = '0;
    send_frame(5, 5, 1, 1, 25);
    wait_done(25, 200);
    check("tog_win00", cap00, 72'h000000000102000607);
    check("tog_win22", cap22, 72'h0708090C0D0E111213);
    check("tog_win44", cap44, 72'h131400181900000000);

    // Random pixels, random gaps
    for (int t = 0; t < 3; t++) begin
      fill_rand(5, 5);
      send_frame(5, 5, 1, 2, 25);
      wait_done(25, 200);
    end

    // Full 32x32 frame
    sel = 1;
    fill_seq(32, 32);
    send_frame(32, 32, 1, 0, 1024);
    wait_done(1024, 3000);
    check("win_last", cap_last, 72'hDFE000FF0000000000);
    check("tail_lat", 72'((last_cyc - pix_cyc[1023]) <= 50), 72'(1));

    // Restart mid-frame after 10 pixels
    sel = 0;
    fill_rand(5, 5);
    send_frame(5, 5, 1, 0, 10);
    fill_rand(5, 5);
    send_frame(5, 5, 1, 2, 25);
    wait_done(25, 200);

    // Reset mid-frame
    fill_rand(5, 5);
    send_frame(5, 5, 1, 0, 12);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 72'(wv), 72'(0));
    check("mid_rst_out", wo, 72'(0));
    check("mid_rst_state", 72'(st), 72'(0));
    rst = 1'b0;
    exp_q.delete();
    got = 0;
    repeat (10) @(posedge clk);
    #1;
    check("no_win_after_rst", 72'(got), 72'(0));
    fill_rand(5, 5);
    send_frame(5, 5, 1, 0, 25);
    wait_done(25, 200);

    // Stride 2
    sel = 2;
    cap22 = '0;
    fill_seq(5, 5);
    send_frame(5, 5, 2, 0, 25);
    wait_done(9, 200);
    check("s2_win22", cap22, 72'h0708090C0D0E111213);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
